// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the encoder and the decode monitor.
// Bit order of every segment code: {g,f,e,d,c,b,a}, bit 0 = segment a, active-high.
package seg7_pkg;

    localparam int unsigned SEG_WIDTH   = 7;
    localparam int unsigned DIGIT_WIDTH = 4;

    localparam logic [SEG_WIDTH-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_WIDTH-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_WIDTH-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_WIDTH-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_WIDTH-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_WIDTH-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        LOCKED     = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic                   valid;
        logic [DIGIT_WIDTH-1:0] digit;
    } seg_decode_t;

    // Map a segment code back to its digit; anything outside the table is invalid.
    function automatic seg_decode_t seg7_decode(input logic [SEG_WIDTH-1:0] code);
        seg_decode_t res;
        res.valid = 1'b1;
        res.digit = 4'd0;
        case (code)
            SEG_0:     res.digit = 4'd0;
            SEG_1:     res.digit = 4'd1;
            SEG_2:     res.digit = 4'd2;
            SEG_3:     res.digit = 4'd3;
            SEG_4:     res.digit = 4'd4;
            SEG_5:     res.digit = 4'd5;
            SEG_6:     res.digit = 4'd6;
            SEG_7:     res.digit = 4'd7;
            SEG_8:     res.digit = 4'd8;
            SEG_9:     res.digit = 4'd9;
            SEG_BLANK: res.valid = 1'b0;
            default:   res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-flop synchroniser followed by a stability filter that strobes once per new stable pattern.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEG_WIDTH-1:0] segments_in,
    output logic [SEG_WIDTH-1:0] candidate,
    output logic                 accept_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SEG_WIDTH-1:0] sync1;
    logic [SEG_WIDTH-1:0] sync2;
    logic [SEG_WIDTH-1:0] accepted;
    logic [CNT_W-1:0]     count;

    // A pattern is accepted once it has held long enough and differs from the last one accepted.
    assign accept_c = (count == CNT_MAX) && (candidate != accepted);

    // Synchroniser stages
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= segments_in;
            sync2 <= sync1;
        end
    end

    // Candidate tracking with saturating stability count
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= '0;
            count     <= '0;
        end else if (sync2 != candidate) begin
            candidate <= sync2;
            count     <= CNT_W'(1);
        end else if (count != CNT_MAX) begin
            count     <= count + CNT_W'(1);
        end
    end

    // Remember the accepted pattern so each stable pattern strobes only once
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted <= '0;
        end else if (accept_c) begin
            accepted <= candidate;
        end
    end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Decodes filtered segment patterns, checks digit sequencing and measures the digit period.
module seg7_decode_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned LAST_DIGIT    = 9,
    parameter int unsigned PERIOD_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEG_WIDTH-1:0]    segments_in,
    input  logic                    clear_errors,
    output logic [DIGIT_WIDTH-1:0]  digit_out,
    output logic                    digit_valid,
    output logic                    change_pulse,
    output logic                    invalid_pattern,
    output logic                    pattern_error,
    output logic                    seq_error,
    output logic [PERIOD_WIDTH-1:0] period_cycles,
    output logic                    period_valid
);

    localparam logic [DIGIT_WIDTH-1:0]  LAST_D  = DIGIT_WIDTH'(LAST_DIGIT);
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

    logic [SEG_WIDTH-1:0]    candidate;
    logic                    accept_c;
    seg_decode_t             dec;
    logic                    digit_ok;
    logic [DIGIT_WIDTH-1:0]  expected;

    mon_state_e              state, state_next;
    logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_next;
    logic [DIGIT_WIDTH-1:0]  digit_next;
    logic                    digit_valid_next;
    logic                    change_next;
    logic                    invalid_next;
    logic                    pattern_error_next;
    logic                    seq_error_next;
    logic [PERIOD_WIDTH-1:0] period_next;
    logic                    period_valid_next;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .segments_in (segments_in),
        .candidate   (candidate),
        .accept_c    (accept_c)
    );

    assign dec      = seg7_decode(candidate);
    assign digit_ok = dec.valid && (dec.digit <= LAST_D);
    assign expected = (digit_out == LAST_D) ? 4'd0 : digit_out + 4'd1;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= WAIT_FIRST;
            period_cnt      <= '0;
            digit_out       <= '0;
            digit_valid     <= 1'b0;
            change_pulse    <= 1'b0;
            invalid_pattern <= 1'b0;
            pattern_error   <= 1'b0;
            seq_error       <= 1'b0;
            period_cycles   <= '0;
            period_valid    <= 1'b0;
        end else begin
            state           <= state_next;
            period_cnt      <= period_cnt_next;
            digit_out       <= digit_next;
            digit_valid     <= digit_valid_next;
            change_pulse    <= change_next;
            invalid_pattern <= invalid_next;
            pattern_error   <= pattern_error_next;
            seq_error       <= seq_error_next;
            period_cycles   <= period_next;
            period_valid    <= period_valid_next;
        end
    end

    // Next-state, sequence check and period measurement on each accepted pattern
    always_comb begin
        state_next         = state;
        digit_next         = digit_out;
        digit_valid_next   = digit_valid;
        change_next        = 1'b0;
        invalid_next       = invalid_pattern;
        pattern_error_next = pattern_error & ~clear_errors;
        seq_error_next     = seq_error & ~clear_errors;
        period_next        = period_cycles;
        period_valid_next  = period_valid;
        period_cnt_next    = period_cnt;

        // Free-running period count while locked, stuck at all-ones on overflow
        if ((state == LOCKED) && (period_cnt != '1)) begin
            period_cnt_next = period_cnt + PER_ONE;
        end

        if (accept_c) begin
            change_next = 1'b1;
            if (digit_ok) begin
                digit_next       = dec.digit;
                digit_valid_next = 1'b1;
                invalid_next     = 1'b0;
                period_cnt_next  = PER_ONE;
                if (state == WAIT_FIRST) begin
                    state_next = LOCKED;
                end else begin
                    if (dec.digit != expected) begin
                        seq_error_next = 1'b1;
                    end
                    period_next       = period_cnt;
                    period_valid_next = 1'b1;
                end
            end else begin
                invalid_next       = 1'b1;
                digit_valid_next   = 1'b0;
                pattern_error_next = 1'b1;
                state_next         = WAIT_FIRST;
                period_cnt_next    = '0;
                period_valid_next  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed self-checking bench for seg7_decode_monitor (STABLE_CYCLES=4, LAST_DIGIT=9).
module tb_seg7_decode_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  segments_in = 7'h00;
    logic        clear_errors = 1'b0;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        change_pulse;
    logic        invalid_pattern;
    logic        pattern_error;
    logic        seq_error;
    logic [23:0] period_cycles;
    logic        period_valid;

    int errors = 0;
    int checks = 0;
    int pulse_count = 0;
    int base = 0;
    logic [6:0] codes [0:9];

    seg7_decode_monitor #(
        .STABLE_CYCLES (4),
        .LAST_DIGIT    (9),
        .PERIOD_WIDTH  (24)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .segments_in     (segments_in),
        .clear_errors    (clear_errors),
        .digit_out       (digit_out),
        .digit_valid     (digit_valid),
        .change_pulse    (change_pulse),
        .invalid_pattern (invalid_pattern),
        .pattern_error   (pattern_error),
        .seq_error       (seq_error),
        .period_cycles   (period_cycles),
        .period_valid    (period_valid)
    );

    always #5 clk = ~clk;

    // Count every change pulse seen at a clock edge
    always @(posedge clk) begin
        if (change_pulse === 1'b1) pulse_count <= pulse_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        segments_in = pat;
        step(n);
    endtask

    task automatic do_reset();
        segments_in = 7'h00;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(5);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit_out"}, 32'(digit_out), 0);
        check({tag, "_digit_valid"}, 32'(digit_valid), 0);
        check({tag, "_change_pulse"}, 32'(change_pulse), 0);
        check({tag, "_invalid"}, 32'(invalid_pattern), 0);
        check({tag, "_pattern_error"}, 32'(pattern_error), 0);
        check({tag, "_seq_error"}, 32'(seq_error), 0);
        check({tag, "_period_cycles"}, 32'(period_cycles), 0);
        check({tag, "_period_valid"}, 32'(period_valid), 0);
    endtask

    initial begin
        codes[0] = 7'h3F; codes[1] = 7'h06; codes[2] = 7'h5B; codes[3] = 7'h4F;
        codes[4] = 7'h66; codes[5] = 7'h6D; codes[6] = 7'h7D; codes[7] = 7'h07;
        codes[8] = 7'h7F; codes[9] = 7'h6F;

        // 1: reset state, then first digit latency
        step(1);
        do_reset();
        check_all_zero("t1_reset");
        segments_in = 7'h3F;
        step(6);
        check("t1_no_pulse_early", 32'(change_pulse), 0);
        step(1);
        check("t1_pulse", 32'(change_pulse), 1);
        check("t1_digit", 32'(digit_out), 0);
        check("t1_valid", 32'(digit_valid), 1);
        check("t1_period_valid", 32'(period_valid), 0);
        check("t1_seq_error", 32'(seq_error), 0);
        check("t1_pattern_error", 32'(pattern_error), 0);
        step(1);
        check("t1_pulse_one_cycle", 32'(change_pulse), 0);

        // 2: short glitch is filtered
        step(20);
        base = pulse_count;
        hold(7'h06, 3);
        hold(7'h3F, 20);
        check("t2_no_pulse", 32'(pulse_count - base), 0);
        check("t2_digit", 32'(digit_out), 0);

        // 3: full sequence 0..9,0 at 100 cycles per digit
        do_reset();
        base = pulse_count;
        for (int i = 0; i <= 10; i++) begin
            hold(codes[i % 10], 100);
            if (i == 1) begin
                check("t3_period_2nd", 32'(period_cycles), 100);
                check("t3_pvalid_2nd", 32'(period_valid), 1);
            end
        end
        check("t3_pulses", 32'(pulse_count - base), 11);
        check("t3_seq_error", 32'(seq_error), 0);
        check("t3_period", 32'(period_cycles), 100);
        check("t3_period_valid", 32'(period_valid), 1);
        check("t3_digit_wrap", 32'(digit_out), 0);

        // 4: skipped digit sets sticky seq_error, clear_errors clears it
        do_reset();
        hold(7'h5B, 20);
        hold(7'h4F, 20);
        check("t4_no_error_3", 32'(seq_error), 0);
        segments_in = 7'h6D;
        step(7);
        check("t4_pulse_5", 32'(change_pulse), 1);
        check("t4_seq_error_5", 32'(seq_error), 1);
        check("t4_digit_5", 32'(digit_out), 5);
        step(10);
        check("t4_sticky", 32'(seq_error), 1);
        clear_errors = 1'b1;
        step(1);
        clear_errors = 1'b0;
        check("t4_cleared", 32'(seq_error), 0);
        hold(7'h7D, 20);
        check("t4_no_error_6", 32'(seq_error), 0);
        check("t4_digit_6", 32'(digit_out), 6);

        // 5: invalid pattern drops back to WAIT_FIRST
        do_reset();
        hold(7'h4F, 20);
        hold(7'h66, 20);
        check("t5_locked_err", 32'(seq_error), 0);
        check("t5_period_20", 32'(period_cycles), 20);
        check("t5_pvalid", 32'(period_valid), 1);
        hold(7'h49, 20);
        check("t5_invalid", 32'(invalid_pattern), 1);
        check("t5_pattern_error", 32'(pattern_error), 1);
        check("t5_digit_valid", 32'(digit_valid), 0);
        check("t5_digit_hold", 32'(digit_out), 4);
        check("t5_pvalid_cleared", 32'(period_valid), 0);
        hold(7'h66, 20);
        check("t5_relock_err", 32'(seq_error), 0);
        check("t5_relock_valid", 32'(digit_valid), 1);
        check("t5_relock_invalid", 32'(invalid_pattern), 0);
        check("t5_pattern_sticky", 32'(pattern_error), 1);
        check("t5_relock_pvalid", 32'(period_valid), 0);
        hold(7'h6D, 20);
        check("t5_next_err", 32'(seq_error), 0);
        check("t5_next_digit", 32'(digit_out), 5);
        check("t5_next_period", 32'(period_cycles), 20);
        check("t5_next_pvalid", 32'(period_valid), 1);

        // 6: reset mid-sequence discards everything
        do_reset();
        hold(7'h6D, 20);
        hold(7'h07, 20);
        check("t6_pre_err", 32'(seq_error), 1);
        check("t6_pre_digit", 32'(digit_out), 7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all_zero("t6_reset");
        segments_in = 7'h5B;
        step(7);
        check("t6_pulse", 32'(change_pulse), 1);
        check("t6_digit", 32'(digit_out), 2);
        check("t6_valid", 32'(digit_valid), 1);
        check("t6_seq_error", 32'(seq_error), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
